// File: rtl/timer_bcd_bank.sv
// timer_bcd_bank: bank of BCD hh:mm:ss countdown timers on the PicoBlaze port bus
module timer_bcd_bank #(
  parameter int         CHANNELS = 2,
  parameter logic [7:0] BASE_ID  = 8'h40,
  parameter int         TICK_DIV = 100000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            port_id,
  input  logic                  write_strobe,
  input  logic [7:0]            out_port,
  output logic [7:0]            in_port,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  output logic [8*CHANNELS-1:0] ht,
  output logic [8*CHANNELS-1:0] mt,
  output logic [8*CHANNELS-1:0] st,
  output logic [CHANNELS-1:0]   running,
  output logic [CHANNELS-1:0]   Listo_ht
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CHANNELS-1:0][7:0] ht_q, ht_d, mt_q, mt_d, st_q, st_d;
  logic [CHANNELS-1:0] run_q, run_d, done_q, done_d;
  logic [7:0] in_port_q, in_port_d;
  logic irq_q, irq_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0] off;
  logic hit, tick, nib_ok;
  logic [7:0] clamp;
  function automatic logic [7:0] bcd_dec(input logic [7:0] x);
    return (x[3:0] == 4'h0) ? {x[7:4] - 4'h1, 4'h9} : {x[7:4], x[3:0] - 4'h1};
  endfunction
  assign off    = {1'b0, port_id} - {1'b0, BASE_ID};
  assign hit    = off < 9'(4 * CHANNELS);
  assign tick   = cnt_q == CW'(TICK_DIV - 1);
  assign nib_ok = out_port[7:4] < 4'hA && out_port[3:0] < 4'hA;
  assign clamp  = out_port > 8'h59 ? 8'h59 : out_port;
  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    ht_d      = ht_q;
    mt_d      = mt_q;
    st_d      = st_q;
    run_d     = run_q;
    done_d    = done_q;
    in_port_d = 8'h00;
    for (int c = 0; c < CHANNELS; c++) begin
      if (hit && off[4:2] == 3'(c)) begin
        in_port_d = off[1:0] == 2'd0 ? ht_q[c] :
                    off[1:0] == 2'd1 ? mt_q[c] :
                    off[1:0] == 2'd2 ? st_q[c] : {6'b0, done_q[c], run_q[c]};
        if (write_strobe && off[1:0] == 2'd3) begin
          if (out_port[2]) done_d[c] = 1'b0;
          if (out_port[1]) run_d[c] = 1'b0;
          else if (out_port[0] && !run_q[c]) begin
            run_d[c]  = |{ht_q[c], mt_q[c], st_q[c]};
            done_d[c] = ~|{ht_q[c], mt_q[c], st_q[c]};
          end
        end else if (write_strobe && !run_q[c] && nib_ok) begin
          ht_d[c] = off[1:0] == 2'd0 ? out_port : ht_q[c];
          mt_d[c] = off[1:0] == 2'd1 ? clamp : mt_q[c];
          st_d[c] = off[1:0] == 2'd2 ? clamp : st_q[c];
        end
      end
      if (tick && run_q[c] && run_d[c]) begin
        st_d[c] = st_q[c] != 8'h00 ? bcd_dec(st_q[c]) : 8'h59;
        mt_d[c] = st_q[c] != 8'h00 ? mt_q[c] : mt_q[c] != 8'h00 ? bcd_dec(mt_q[c]) : 8'h59;
        ht_d[c] = (st_q[c] != 8'h00 || mt_q[c] != 8'h00) ? ht_q[c] : bcd_dec(ht_q[c]);
        if (st_q[c] == 8'h01 && mt_q[c] == 8'h00 && ht_q[c] == 8'h00) begin
          run_d[c]  = 1'b0;
          done_d[c] = 1'b1;
        end
      end
    end
    irq_d = |(done_d & ~done_q) ? 1'b1 : interrupt_ack ? 1'b0 : irq_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ht_q      <= '0;
      mt_q      <= '0;
      st_q      <= '0;
      run_q     <= '0;
      done_q    <= '0;
      in_port_q <= 8'h00;
      irq_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ht_q      <= ht_d;
      mt_q      <= mt_d;
      st_q      <= st_d;
      run_q     <= run_d;
      done_q    <= done_d;
      in_port_q <= in_port_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
    end
  end
  assign ht        = ht_q;
  assign mt        = mt_q;
  assign st        = st_q;
  assign running   = run_q;
  assign Listo_ht  = done_q;
  assign in_port   = in_port_q;
  assign interrupt = irq_q;
endmodule

// File: tb/tb_timer_bcd_bank.sv
// tb_timer_bcd_bank: directed checks of the BCD timer bank with a 4-cycle tick
module tb_timer_bcd_bank;
  logic clk = 1'b0, reset = 1'b1, write_strobe = 1'b0, interrupt_ack = 1'b0, interrupt;
  logic [7:0] port_id = 8'h00, out_port = 8'h00, in_port, r;
  logic [15:0] ht, mt, st;
  logic [1:0] running, listo;
  int cyc = 0, checks = 0, passes = 0;
  timer_bcd_bank #(.CHANNELS(2), .BASE_ID(8'h40), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .write_strobe(write_strobe),
    .out_port(out_port), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .ht(ht), .mt(mt), .st(st),
    .running(running), .Listo_ht(listo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %02h expected %02h", name, obs, exp);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a;
    out_port = d;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    port_id = a;
    @(negedge clk);
    v = in_port;
  endtask
  task automatic to_tick;
    do @(negedge clk); while (cyc % 4 != 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ht", ht[7:0], 8'h00);
    chk("rst_mt", mt[15:8], 8'h00);
    chk("rst_st", st[7:0], 8'h00);
    chk("rst_run", 8'(running), 8'h00);
    chk("rst_done", 8'(listo), 8'h00);
    chk("rst_irq", 8'(interrupt), 8'h00);
    chk("rst_inport", in_port, 8'h00);
    reset = 1'b0;
    rd(8'h43, r);
    chk("rd_status_idle", r, 8'h00);
    wr(8'h40, 8'h00);
    wr(8'h41, 8'h01);
    wr(8'h42, 8'h02);
    wr(8'h43, 8'h01);
    chk("start_run", 8'(running), 8'h01);
    chk("start_st", st[7:0], 8'h02);
    to_tick;
    chk("tick1_st", st[7:0], 8'h01);
    chk("tick1_mt", mt[7:0], 8'h01);
    to_tick;
    to_tick;
    chk("tick3_st", st[7:0], 8'h59);
    chk("tick3_mt", mt[7:0], 8'h00);
    repeat (58) to_tick;
    chk("tick61_st", st[7:0], 8'h01);
    chk("tick61_done", 8'(listo), 8'h00);
    to_tick;
    chk("tick62_st", st[7:0], 8'h00);
    chk("tick62_run", 8'(running), 8'h00);
    chk("tick62_done", 8'(listo), 8'h01);
    chk("tick62_irq", 8'(interrupt), 8'h01);
    rd(8'h43, r);
    chk("rd_status_done", r, 8'h02);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    chk("ack_irq", 8'(interrupt), 8'h00);
    chk("ack_done_kept", 8'(listo), 8'h01);
    wr(8'h43, 8'h04);
    chk("clr_done", 8'(listo), 8'h00);
    wr(8'h44, 8'h01);
    wr(8'h45, 8'h00);
    wr(8'h46, 8'h00);
    wr(8'h47, 8'h01);
    chk("ch1_run", 8'(running), 8'h02);
    to_tick;
    chk("borrow_ht", ht[15:8], 8'h00);
    chk("borrow_mt", mt[15:8], 8'h59);
    chk("borrow_st", st[15:8], 8'h59);
    chk("borrow_ch0_mt", mt[7:0], 8'h00);
    chk("borrow_ch0_st", st[7:0], 8'h00);
    wr(8'h47, 8'h02);
    chk("ch1_stop", 8'(running), 8'h00);
    chk("ch1_stop_st", st[15:8], 8'h59);
    wr(8'h41, 8'h7A);
    chk("bad_nibble", mt[7:0], 8'h00);
    wr(8'h41, 8'h75);
    chk("clamp_mt", mt[7:0], 8'h59);
    wr(8'h40, 8'h99);
    chk("hours_99", ht[7:0], 8'h99);
    wr(8'h40, 8'h0A);
    chk("hours_bad", ht[7:0], 8'h99);
    wr(8'h40, 8'h00);
    wr(8'h42, 8'h05);
    wr(8'h43, 8'h01);
    chk("ch0_run", 8'(running), 8'h01);
    rd(8'h43, r);
    chk("rd_status_run", r, 8'h01);
    wr(8'h40, 8'h11);
    wr(8'h41, 8'h22);
    wr(8'h42, 8'h30);
    chk("run_wr_ht", ht[7:0], 8'h00);
    chk("run_wr_mt", mt[7:0], 8'h59);
    wr(8'h48, 8'h12);
    chk("oor_ht1", ht[15:8], 8'h00);
    chk("oor_mt1", mt[15:8], 8'h59);
    chk("oor_st1", st[15:8], 8'h59);
    rd(8'h48, r);
    chk("oor_rd48", r, 8'h00);
    rd(8'h3F, r);
    chk("oor_rd3f", r, 8'h00);
    wr(8'h43, 8'h02);
    chk("ch0_stop", 8'(running), 8'h00);
    wr(8'h41, 8'h00);
    wr(8'h42, 8'h10);
    chk("load_st", st[7:0], 8'h10);
    wr(8'h43, 8'h03);
    chk("start_stop_same", 8'(running), 8'h00);
    to_tick;
    wr(8'h43, 8'h01);
    to_tick;
    chk("restart_st", st[7:0], 8'h09);
    while (cyc % 4 != 3) @(negedge clk);
    wr(8'h43, 8'h02);
    chk("stop_tick_run", 8'(running), 8'h00);
    chk("stop_tick_st", st[7:0], 8'h09);
    to_tick;
    chk("stopped_st", st[7:0], 8'h09);
    wr(8'h45, 8'h00);
    wr(8'h46, 8'h00);
    chk("zero_mt1", mt[15:8], 8'h00);
    chk("pre_zero_irq", 8'(interrupt), 8'h00);
    wr(8'h47, 8'h01);
    chk("zero_done", 8'(listo), 8'h02);
    chk("zero_irq", 8'(interrupt), 8'h01);
    chk("zero_run", 8'(running), 8'h00);
    wr(8'h47, 8'h04);
    chk("zero_clr", 8'(listo), 8'h00);
    interrupt_ack = 1'b1;
    wr(8'h47, 8'h01);
    interrupt_ack = 1'b0;
    chk("ack_vs_set_irq", 8'(interrupt), 8'h01);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    chk("ack2_irq", 8'(interrupt), 8'h00);
    wr(8'h43, 8'h01);
    to_tick;
    chk("pre_rst_st", st[7:0], 8'h08);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_st", st[7:0], 8'h00);
    chk("midrst_run", 8'(running), 8'h00);
    chk("midrst_done", 8'(listo), 8'h00);
    chk("midrst_irq", 8'(interrupt), 8'h00);
    reset = 1'b0;
    repeat (3) to_tick;
    chk("post_rst_done", 8'(listo), 8'h00);
    chk("post_rst_irq", 8'(interrupt), 8'h00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/timer_bcd_bank.md
# timer_bcd_bank

Parametrised bank of independent BCD countdown timers (hours:minutes:seconds) on the PicoBlaze port bus, next to the keyboard and RTC register blocks. Firmware loads each channel's hours/minutes/seconds and start/stop/clear commands through OUTPUT instructions, and reads status through INPUT instructions. Every channel counts down once per internally generated one-second tick and raises a sticky done flag at 00:00:00. A shared interrupt line goes to the processor.

## Interface
- CHANNELS, 2: number of timers, 1..8.
- BASE_ID, 8'h40: first port ID of the bank. Must be a multiple of 4, and BASE_ID+4*CHANNELS ≤ 256.
- TICK_DIV, 100000000: clk cycles per one-second tick, ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- port_id  in  8  PicoBlaze port address.
- write_strobe  in  1  write qualifier for out_port.
- out_port  in  8  write data.
- in_port  out  8  registered read data.
- interrupt  out  1  PicoBlaze interrupt request.
- interrupt_ack  in  1  PicoBlaze acknowledge.
- ht  out  8*CHANNELS  BCD hours per channel, channel c at [8c+7:8c].
- mt  out  8*CHANNELS  BCD minutes.
- st  out  8*CHANNELS  BCD seconds.
- running  out  CHANNELS  channel counting.
- Listo_ht  out  CHANNELS  sticky done flag per channel.

## Operation
- Address map for channel c, with a = BASE_ID+4c:
  - a+0: hours.
  - a+1: minutes.
  - a+2: seconds.
  - a+3: control on write, status on read.
- IDs outside BASE_ID..BASE_ID+4*CHANNELS-1: writes are ignored and reads return 8'h00.
- Field write (write_strobe=1, stopped channel only):
  - Either nibble > 9: the write is ignored.
  - Minutes or seconds > 8'h59: the value stored is 8'h59.
  - Hours range is 8'h00..8'h99.
  - Field writes to a running channel are ignored.
- Control write bits:
  - bit0 start: if the channel is stopped, set running and clear done.
  - bit1 stop: clear running.
  - bit2 clr: clear done.
  - Other bits are ignored.
  - Start and stop in the same write: stop wins.
  - Start while running: no effect.
- Start with fields all 00: running stays 0. Done sets on the next edge, with an interrupt.
- Status read: {6'b0, done, running}.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick is asserted for one cycle when the count equals TICK_DIV-1.
  - Counter width is clog2(TICK_DIV).
- On tick, each running channel decrements with BCD borrow:
  - st ≠ 00: st−1. A low nibble of 0 becomes 9 and the high nibble decrements.
  - st = 00, mt ≠ 00: st = 59, mt−1.
  - st = mt = 00, ht ≠ 00: st = 59, mt = 59, ht−1.
- When a decrement produces 00:00:00, on that same edge: running is cleared and done is set.
- Precedence per channel per edge:
  - Stop write beats tick: no decrement.
  - Start write cycle: no decrement.
  - Done set beats clr.
- interrupt:
  - Set on any channel's done 0→1 transition.
  - Cleared by interrupt_ack.
  - A new rise in the same cycle as ack: set wins.
- Reset mid-count: everything returns to reset values immediately. No done and no interrupt are produced.

## Timing
- Reset values:
  - ht, mt, st: 8'h00.
  - running, Listo_ht: 0.
  - in_port: 8'h00.
  - interrupt: 0.
  - Prescaler: 0.
- All outputs are registered. Writes are visible one cycle after the write_strobe edge.
- Read latency: in_port reflects the port_id of the previous cycle.
  - It is updated every cycle regardless of read_strobe.
  - It is valid by the second cycle of the INPUT instruction.
- First tick comes TICK_DIV cycles after reset is released. Ticks then repeat every TICK_DIV cycles; start does not resynchronise the prescaler.
- A load of N seconds total reaches done on the N-th tick after start.
- Done is stable until cleared by clr, start, or reset.

## Test plan
- Reset: hold reset 3 cycles -> all outputs 0. Read port 0x43 -> in_port 0x00.
- Basic count (CHANNELS=2, BASE_ID=0x40, TICK_DIV=4):
  - Write 0x40←00, 0x41←01, 0x42←02, 0x43←01.
  - After 1 tick -> 00:01:01.
  - After 62 ticks -> 00:00:00, running=0, Listo_ht[0]=1, interrupt=1.
  - interrupt_ack -> interrupt=0 while Listo_ht stays 1.
  - Write 0x43←04 -> done=0.
- Borrow chain: load ch1 01:00:00 (ports 0x44..0x46), start via 0x47 -> after 1 tick, 00:59:59. Ch0 is unchanged.
- Validation:
  - 0x41←0x7A is ignored.
  - 0x41←0x75 stores 0x59.
  - Writes to 0x40..0x42 while running are ignored.
  - Write 0x48←0x12 (out of range) -> no effect; reading 0x48 gives 0x00.
- Command conflicts:
  - 0x43←0x03 -> running stays 0.
  - Stop write coincident with tick -> no decrement.
  - Start with 00:00:00 -> done=1 and interrupt=1 one cycle later, running=0.
- Status read: running ch0, read 0x43 -> in_port = 0x01 one cycle later. After done -> 0x02.
